lsu_axi_gen: RTL and testbench

//  Parametrised load/store unit between EXU and an AXI4-Lite data port, for 32- or 64-bit cores.

---
 rtl/lsu_axi_gen.sv | 182 ++++++++++++++++++
 tb/tb_lsu_axi_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_gen.sv
// Load/store unit bridging EXU requests onto an AXI4-Lite data port, one access outstanding.
// Loads are aligned and extended, stores are lane-shifted, and errors come back as a tagged response.
module lsu_axi_gen #(
  parameter int DATA_LEN = 64,
  localparam int STRB_W = DATA_LEN / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_wen,
  output logic [1:0]          resp_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_LEN-1:0] awaddr,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_LEN-1:0] wdata,
  output logic [STRB_W-1:0]   wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [DATA_LEN-1:0] araddr,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          rresp
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RESP} state_t;

  state_t                state, state_next;
  logic                  aw_done, w_done, aw_done_next, w_done_next;
  logic                  accept, misaligned;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [DATA_LEN-1:0]   addr_q;
  logic [OFF_W-1:0]      req_off;
  logic [3:0]            req_bytes;
  logic [STRB_W-1:0]     lane_mask, st_wstrb;
  logic [DATA_LEN-1:0]   st_wdata;
  logic [DATA_LEN-1:0]   rd_sh, keep, load_ext;
  logic [6:0]            nbits;
  logic                  sign;

  assign accept = req_valid & req_ready;
  assign awaddr = addr_q;
  assign araddr = addr_q;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = (DATA_LEN == 32) || (|req_addr[2:0]);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    req_off   = req_addr[OFF_W-1:0];
    req_bytes = 4'd1 << req_size;
    lane_mask = (STRB_W'(1) << req_bytes) - STRB_W'(1);
    st_wstrb  = lane_mask << req_off;
    st_wdata  = req_wdata << {req_off, 3'b000};
  end

  // keep marks the surviving low bits; its top bit selects the sign position
  always_comb begin
    rd_sh = rdata >> {addr_q[OFF_W-1:0], 3'b000};
    nbits = 7'd8 << size_q;
    if (int'(nbits) > DATA_LEN) nbits = 7'(DATA_LEN);
    keep     = (DATA_LEN'(1) << nbits) - DATA_LEN'(1);
    sign     = |(rd_sh & keep & ~(keep >> 1));
    load_ext = (rd_sh & keep) | ((sign && !unsigned_q) ? ~keep : '0);
  end

  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    case (state)
      IDLE: begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (accept) begin
          if (misaligned)        state_next = RESP;
          else if (req_is_store) state_next = WR_AW_W;
          else                   state_next = RD_AR;
        end
      end
      RD_AR:   if (arready) state_next = RD_R;
      RD_R:    if (rvalid)  state_next = RESP;
      WR_AW_W: begin
        aw_done_next = aw_done | (awvalid & awready);
        w_done_next  = w_done  | (wvalid & wready);
        if (aw_done_next && w_done_next) state_next = WR_B;
      end
      WR_B:    if (bvalid)     state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  // handshake outputs are flops decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_wen   <= 1'b0;
    end else begin
      req_ready  <= (state_next == IDLE);
      arvalid    <= (state_next == RD_AR);
      rready     <= (state_next == RD_R);
      awvalid    <= (state_next == WR_AW_W) && !aw_done_next;
      wvalid     <= (state_next == WR_AW_W) && !w_done_next;
      bready     <= (state_next == WR_B);
      resp_valid <= (state_next == RESP);
      resp_wen   <= (state == RD_R) && rvalid && (rresp == 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      resp_err   <= 2'd0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata      <= st_wdata;
        wstrb      <= st_wstrb;
        resp_err   <= misaligned ? 2'd1 : 2'd0;
        resp_rdata <= '0;
      end
      if (state == RD_R && rvalid) begin
        resp_err   <= (rresp != 2'd0) ? 2'd2 : 2'd0;
        resp_rdata <= (rresp != 2'd0) ? '0 : load_ext;
      end
      if (state == WR_B && bvalid) resp_err <= (bresp != 2'd0) ? 2'd2 : 2'd0;
      if (state == RESP && resp_ready) begin
        resp_err   <= 2'd0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_gen.sv
// Scoreboard bench for lsu_axi_gen (DATA_LEN=64) against a reactive AXI4-Lite slave.
// Expected responses are queued when a request is driven and compared when resp_valid appears.
module tb_lsu_axi_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_wen;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  logic        ar_en = 1'b1, r_en = 1'b1, aw_en = 1'b1, w_en = 1'b1, b_en = 1'b1;
  logic [63:0] slv_rdata = '0;
  logic [1:0]  slv_rresp = 2'd0, slv_bresp = 2'd0;

  int n_cmp = 0, n_bad = 0;
  int ar_cycles = 0, aw_hs = 0, w_hs = 0;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  err;
    logic        wen;
  } exp_t;
  exp_t sb[$];

  lsu_axi_gen #(.DATA_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_wen(resp_wen), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  assign arready = ar_en & rst_n;

  // reactive slave: answers whatever the LSU is waiting for, gated by the *_en knobs
  always @(negedge clk) begin
    if (!rst_n) begin
      rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rdata = '0; rresp = 2'd0; bresp = 2'd0;
    end else begin
      rvalid  = rready && r_en;
      rdata   = slv_rdata;
      rresp   = slv_rresp;
      awready = awvalid && aw_en;
      wready  = wvalid && w_en;
      bvalid  = bready && b_en;
      bresp   = slv_bresp;
    end
  end

  always @(posedge clk) begin
    if (arvalid) ar_cycles++;
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready) w_hs++;
  end

  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] off,
                                           input logic [1:0] sz, input logic u);
    logic [63:0] s;
    s = d >> (off * 8);
    case (sz)
      2'd0:    return u ? {56'b0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
      2'd1:    return u ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    return u ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  // called at a negedge with the LSU idle; returns at the negedge after the accepting edge
  task automatic do_req(input logic st, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] wd);
    req_is_store = st; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_is_store = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
  endtask

  // lat counts edges from the accepting edge to the first resp_valid cycle
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if ({resp_valid, resp_wen, arvalid, awvalid, wvalid, bready, rready} !== 7'b0) begin
      n_bad++; $display("FAIL reset_outputs got %b want 0", {resp_valid, resp_wen, arvalid, awvalid, wvalid, bready, rready}); end
    n_cmp++; if ({resp_rdata, resp_err, wstrb} !== '0) begin
      n_bad++; $display("FAIL reset_data got %h/%0d/%h want 0", resp_rdata, resp_err, wstrb); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_signed();
    exp_t e; int lat;
    slv_rdata = 64'h0000_0000_8000_0000;
    do_req(1'b0, 2'd0, 1'b0, 64'h1003, '0);
    sb.push_back('{rdata: 64'hFFFF_FFFF_FFFF_FF80, err: 2'd0, wen: 1'b1});
    wait_resp(lat);
    e = sb.pop_front();
    n_cmp++; if (!resp_valid) begin n_bad++; $display("FAIL lb_timeout got resp_valid=0 want 1"); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lb_latency got %0d want 3", lat); end
    n_cmp++; if (resp_rdata !== e.rdata) begin n_bad++; $display("FAIL lb_rdata got %h want %h", resp_rdata, e.rdata); end
    n_cmp++; if ({resp_err, resp_wen} !== {e.err, e.wen}) begin
      n_bad++; $display("FAIL lb_err_wen got %0d/%b want %0d/%b", resp_err, resp_wen, e.err, e.wen); end
    @(negedge clk);
    n_cmp++; if ({resp_valid, resp_wen} !== 2'b10) begin
      n_bad++; $display("FAIL lb_wen_pulse got valid/wen %b want 10", {resp_valid, resp_wen}); end
    n_cmp++; if (resp_rdata !== e.rdata) begin n_bad++; $display("FAIL lb_rdata_hold got %h want %h", resp_rdata, e.rdata); end
    finish_resp();
  endtask

  task automatic test_load_unsigned();
    exp_t e; int lat;
    slv_rdata = 64'h9ABC_DEF0_1234_5678;
    do_req(1'b0, 2'd2, 1'b1, 64'h2004, '0);
    sb.push_back('{rdata: 64'h0000_0000_9ABC_DEF0, err: 2'd0, wen: 1'b1});
    n_cmp++; if ({arvalid, araddr} !== {1'b1, 64'h2004}) begin
      n_bad++; $display("FAIL lwu_araddr got %b/%h want 1/2004", arvalid, araddr); end
    wait_resp(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lwu_latency got %0d want 3", lat); end
    n_cmp++; if (resp_rdata !== e.rdata) begin n_bad++; $display("FAIL lwu_rdata got %h want %h", resp_rdata, e.rdata); end
    n_cmp++; if ({resp_err, resp_wen} !== {e.err, e.wen}) begin
      n_bad++; $display("FAIL lwu_err_wen got %0d/%b want %0d/%b", resp_err, resp_wen, e.err, e.wen); end
    finish_resp();
  endtask

  task automatic test_store_half();
    exp_t e; int lat, aw0, w0;
    aw0 = aw_hs; w0 = w_hs;
    aw_en = 1'b0; w_en = 1'b1;
    do_req(1'b1, 2'd1, 1'b0, 64'h3006, 64'hBEEF);
    sb.push_back('{rdata: 64'h0, err: 2'd0, wen: 1'b0});
    n_cmp++; if ({awvalid, wvalid} !== 2'b11) begin n_bad++; $display("FAIL sh_valids got %b want 11", {awvalid, wvalid}); end
    n_cmp++; if (wdata !== 64'hBEEF_0000_0000_0000) begin n_bad++; $display("FAIL sh_wdata got %h want beef000000000000", wdata); end
    n_cmp++; if (wstrb !== 8'hC0) begin n_bad++; $display("FAIL sh_wstrb got %h want c0", wstrb); end
    n_cmp++; if (awaddr !== 64'h3006) begin n_bad++; $display("FAIL sh_awaddr got %h want 3006", awaddr); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({awvalid, wvalid} !== 2'b10) begin n_bad++; $display("FAIL sh_aw_held got %b want 10", {awvalid, wvalid}); end
    @(posedge clk);
    #1 aw_en = 1'b1;
    @(negedge clk);
    wait_resp(lat);
    e = sb.pop_front();
    n_cmp++; if (!resp_valid) begin n_bad++; $display("FAIL sh_timeout got resp_valid=0 want 1"); end
    n_cmp++; if ({resp_rdata, resp_err, resp_wen} !== {e.rdata, e.err, e.wen}) begin
      n_bad++; $display("FAIL sh_resp got %h/%0d/%b want %h/%0d/%b", resp_rdata, resp_err, resp_wen, e.rdata, e.err, e.wen); end
    n_cmp++; if ({aw_hs - aw0, w_hs - w0} !== {32'd1, 32'd1}) begin
      n_bad++; $display("FAIL sh_beats got aw=%0d w=%0d want 1/1", aw_hs - aw0, w_hs - w0); end
    finish_resp();
  endtask

  task automatic test_misalign();
    exp_t e; int lat, ar0;
    ar0 = ar_cycles;
    do_req(1'b0, 2'd2, 1'b0, 64'h4002, '0);
    sb.push_back('{rdata: 64'h0, err: 2'd1, wen: 1'b0});
    wait_resp(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mis_latency got %0d want 1", lat); end
    n_cmp++; if ({resp_rdata, resp_err, resp_wen} !== {e.rdata, e.err, e.wen}) begin
      n_bad++; $display("FAIL mis_resp got %h/%0d/%b want %h/%0d/%b", resp_rdata, resp_err, resp_wen, e.rdata, e.err, e.wen); end
    finish_resp();
    n_cmp++; if (ar_cycles !== ar0) begin n_bad++; $display("FAIL mis_no_ar got %0d arvalid cycles want 0", ar_cycles - ar0); end
  endtask

  task automatic test_store_buserr();
    exp_t e; int lat;
    slv_bresp = 2'd2;
    do_req(1'b1, 2'd3, 1'b0, 64'h5008, 64'h0123_4567_89AB_CDEF);
    sb.push_back('{rdata: 64'h0, err: 2'd2, wen: 1'b0});
    n_cmp++; if (wstrb !== 8'hFF) begin n_bad++; $display("FAIL sd_wstrb got %h want ff", wstrb); end
    wait_resp(lat);
    e = sb.pop_front();
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sd_latency got %0d want 3", lat); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({resp_valid, resp_err, resp_wen, resp_rdata} !== {1'b1, e.err, e.wen, e.rdata}) begin
        n_bad++; $display("FAIL sd_hold%0d got %b/%0d/%b/%h want 1/%0d/%b/%h", i, resp_valid, resp_err, resp_wen, resp_rdata, e.err, e.wen, e.rdata); end
      if (i < 3) @(negedge clk);
    end
    finish_resp();
    slv_bresp = 2'd0;
    n_cmp++; if ({req_ready, resp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL sd_idle got ready/valid %b want 10", {req_ready, resp_valid}); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat, n;
    r_en = 1'b0;
    do_req(1'b0, 2'd3, 1'b0, 64'h6000, '0);
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_reach_rd_r got rready=%b want 1", rready); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({arvalid, awvalid, wvalid, rready, bready, resp_valid, req_ready} !== 7'b0000001) begin
      n_bad++; $display("FAIL rst_mid_async got %b want 0000001", {arvalid, awvalid, wvalid, rready, bready, resp_valid, req_ready}); end
    @(negedge clk);
    r_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    slv_rdata = 64'hFEDC_BA98_7654_3210;
    do_req(1'b0, 2'd1, 1'b0, 64'h6006, '0);
    sb.push_back('{rdata: 64'hFFFF_FFFF_FFFF_FEDC, err: 2'd0, wen: 1'b1});
    wait_resp(lat);
    e = sb.pop_front();
    n_cmp++; if ({lat, resp_rdata, resp_err, resp_wen} !== {32'd3, e.rdata, e.err, e.wen}) begin
      n_bad++; $display("FAIL rst_mid_reload got lat=%0d %h/%0d/%b want 3 %h/%0d/%b", lat, resp_rdata, resp_err, resp_wen, e.rdata, e.err, e.wen); end
    finish_resp();
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat;
    logic [1:0] sz; logic u; logic [63:0] a;
    for (int i = 0; i < 8; i++) begin
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom);
      a  = 64'h8000 + 64'($urandom_range(0, 255));
      a  = a & ~((64'd1 << sz) - 64'd1);
      slv_rdata = {$urandom, $urandom};
      slv_rresp = (i == 5) ? 2'd3 : 2'd0;
      do_req(1'b0, sz, u, a, '0);
      if (i == 5) sb.push_back('{rdata: 64'h0, err: 2'd2, wen: 1'b0});
      else        sb.push_back('{rdata: ref_load(slv_rdata, a[2:0], sz, u), err: 2'd0, wen: 1'b1});
      wait_resp(lat);
      e = sb.pop_front();
      n_cmp++; if ({lat, resp_rdata, resp_err, resp_wen} !== {32'd3, e.rdata, e.err, e.wen}) begin
        n_bad++; $display("FAIL b2b%0d sz=%0d u=%b a=%h got lat=%0d %h/%0d/%b want 3 %h/%0d/%b",
                          i, sz, u, a, lat, resp_rdata, resp_err, resp_wen, e.rdata, e.err, e.wen); end
      finish_resp();
    end
    slv_rresp = 2'd0;
  endtask

  initial begin
    test_reset();
    test_load_signed();
    test_load_unsigned();
    test_store_half();
    test_misalign();
    test_store_buserr();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
